// File: rtl/fp_mul_pkg.sv
// Shared types and constant helpers for the sequential floating-point multiplier.
package fp_mul_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } r_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULT  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CL_ZERO = 3'd0,
        CL_NORM = 3'd1,
        CL_INF  = 3'd2,
        CL_QNAN = 3'd3,
        CL_SNAN = 3'd4
    } class_e;

    // Canonical quiet NaN (sign 0), right-aligned in a 64-bit container.
    function automatic logic [63:0] canon_nan(input int exp_w, input int frc_w);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) begin
            v[i] = ((i >= frc_w) && (i < frc_w + exp_w)) || (i == frc_w - 1);
        end
        return v;
    endfunction

    // Largest finite magnitude (sign 0), right-aligned in a 64-bit container.
    function automatic logic [63:0] max_finite(input int exp_w, input int frc_w);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) begin
            v[i] = (i < frc_w) || ((i > frc_w) && (i < frc_w + exp_w));
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_booth_r4_digit.sv
// Radix-4 Booth digit: maps a 3-bit multiplier window onto 0, +-X or +-2X.
module fp_booth_r4_digit
    import fp_mul_pkg::*;
#(
    parameter int M = 24
) (
    input  logic [2:0]          win,
    input  logic [M-1:0]        mant,
    output logic signed [M+1:0] pp
);

    logic signed [M+1:0] x1_s;
    logic signed [M+1:0] x2_s;

    // Select the signed partial product for this digit.
    always_comb begin
        x1_s = $signed({2'b00, mant});
        x2_s = $signed({1'b0, mant, 1'b0});
        case (win)
            3'b001, 3'b010: pp = x1_s;
            3'b011:         pp = x2_s;
            3'b100:         pp = -x2_s;
            3'b101, 3'b110: pp = -x1_s;
            default:        pp = '0;
        endcase
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754-style multiplier: radix-4 Booth mantissa engine, rounding, specials.
// Optional nv output when FP_MUL_NV_FLAG_EN is defined.
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+FRC_W:0]     fp_X,
    input  logic [EXP_W+FRC_W:0]     fp_Y,
    input  logic [2:0]               r_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+FRC_W:0]     fp_Z,
    output logic                     ovrf,
    output logic                     udrf
`ifdef FP_MUL_NV_FLAG_EN
    ,
    output logic                     nv
`endif
);

    localparam int W    = 1 + EXP_W + FRC_W;
    localparam int M    = FRC_W + 1;
    localparam int ITER = M / 2 + 1;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [63:0]      NAN64   = canon_nan(EXP_W, FRC_W);
    localparam logic [63:0]      MAXF64  = max_finite(EXP_W, FRC_W);
    localparam logic [W-1:0]     NAN_W   = NAN64[W-1:0];
    localparam logic [W-1:0]     MAXF_W  = MAXF64[W-1:0];
    localparam logic [EXP_W+1:0] BIAS_X  = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W:0]   EXP_TOP = (EXP_W+1)'((1 << EXP_W) - 1);

    function automatic class_e classify(input logic [W-2:0] v);
        logic [EXP_W-1:0] e;
        logic [FRC_W-1:0] f;
        class_e           c;
        e = v[W-2:FRC_W];
        f = v[FRC_W-1:0];
        if (e == '0)              c = CL_ZERO;
        else if (e != '1)         c = CL_NORM;
        else if (f == '0)         c = CL_INF;
        else if (f[FRC_W-1])      c = CL_QNAN;
        else                      c = CL_SNAN;
        return c;
    endfunction

    state_e           state_r, state_nx_s;
    logic [W-1:0]     x_r, y_r;
    logic [2:0]       rm_r;
    logic [2*M-1:0]   acc_r;
    logic [CW-1:0]    cnt_r;
    logic [W-1:0]     fp_z_r;
    logic             ovrf_r, udrf_r, out_valid_r, in_ready_r;

    class_e           cls_x_s, cls_y_s;
    logic             special_s, inv_s, nan_any_s, inf_any_s, sign_in_s;
    logic [W-1:0]     spec_z_s;

    logic [M-1:0]     mant_x_s;
    logic [M+2:0]     y_ext_s, y_sh_s;
    logic signed [M+1:0] pp_s;
    logic [2*M-1:0]   pp_ext_s, acc_nx_s;

    logic             sign_s, guard_s, sticky_s, inc_s, ovrf_s, udrf_s;
    logic [2*M-1:0]   norm_s;
    logic [M-1:0]     man_s;
    logic [M:0]       man_rnd_s;
    logic [FRC_W-1:0] frac_s;
    logic [EXP_W+1:0] exp_base_s, exp_rnd_s;
    logic [W-1:0]     inf_s, maxf_s, rnd_z_s;

    // Operand classification and the direct result for non-normal operands.
    always_comb begin
        cls_x_s   = classify(fp_X[W-2:0]);
        cls_y_s   = classify(fp_Y[W-2:0]);
        sign_in_s = fp_X[W-1] ^ fp_Y[W-1];
        special_s = (cls_x_s != CL_NORM) || (cls_y_s != CL_NORM);
        inv_s     = ((cls_x_s == CL_INF) && (cls_y_s == CL_ZERO)) ||
                    ((cls_x_s == CL_ZERO) && (cls_y_s == CL_INF));
        nan_any_s = (cls_x_s == CL_QNAN) || (cls_x_s == CL_SNAN) ||
                    (cls_y_s == CL_QNAN) || (cls_y_s == CL_SNAN);
        inf_any_s = (cls_x_s == CL_INF) || (cls_y_s == CL_INF);
        if (nan_any_s || inv_s) begin
            spec_z_s = NAN_W;
        end else if (inf_any_s) begin
            spec_z_s = {sign_in_s, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
        end else begin
            spec_z_s = {sign_in_s, {(W-1){1'b0}}};
        end
    end

    // Multiplier window for the current digit; Y is zero-extended above and has Y[-1]=0.
    always_comb begin
        mant_x_s = {1'b1, x_r[FRC_W-1:0]};
        y_ext_s  = {2'b00, 1'b1, y_r[FRC_W-1:0], 1'b0};
        y_sh_s   = y_ext_s >> {cnt_r, 1'b0};
        pp_ext_s = {{(M-2){pp_s[M+1]}}, pp_s};
        acc_nx_s = acc_r + (pp_ext_s << {cnt_r, 1'b0});
    end

    fp_booth_r4_digit #(.M(M)) u_digit (
        .win  (y_sh_s[2:0]),
        .mant (mant_x_s),
        .pp   (pp_s)
    );

    // Normalise, round and saturate the finished product.
    always_comb begin
        sign_s     = x_r[W-1] ^ y_r[W-1];
        norm_s     = acc_r[2*M-1] ? acc_r : {acc_r[2*M-2:0], 1'b0};
        man_s      = norm_s[2*M-1:M];
        guard_s    = norm_s[M-1];
        sticky_s   = |norm_s[M-2:0];
        exp_base_s = {2'b00, x_r[W-2:FRC_W]} + {2'b00, y_r[W-2:FRC_W]} - BIAS_X
                     + {{(EXP_W+1){1'b0}}, acc_r[2*M-1]};
        case (rm_r)
            RM_RTZ:  inc_s = 1'b0;
            RM_RDN:  inc_s = sign_s & (guard_s | sticky_s);
            RM_RUP:  inc_s = ~sign_s & (guard_s | sticky_s);
            RM_RMM:  inc_s = guard_s;
            default: inc_s = guard_s & (sticky_s | man_s[0]);
        endcase
        man_rnd_s = {1'b0, man_s} + {{M{1'b0}}, inc_s};
        exp_rnd_s = exp_base_s + {{(EXP_W+1){1'b0}}, man_rnd_s[M]};
        frac_s    = man_rnd_s[M] ? man_rnd_s[M-1:1] : man_rnd_s[M-2:0];
        // The exponent MSB is a sign bit: negative or zero means underflow.
        udrf_s    = exp_rnd_s[EXP_W+1] | (exp_rnd_s == '0);
        ovrf_s    = ~exp_rnd_s[EXP_W+1] & (exp_rnd_s[EXP_W:0] >= EXP_TOP);
        inf_s     = {sign_s, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
        maxf_s    = {sign_s, MAXF_W[W-2:0]};
        if (ovrf_s) begin
            case (rm_r)
                RM_RTZ:  rnd_z_s = maxf_s;
                RM_RDN:  rnd_z_s = sign_s ? inf_s : maxf_s;
                RM_RUP:  rnd_z_s = sign_s ? maxf_s : inf_s;
                default: rnd_z_s = inf_s;
            endcase
        end else if (udrf_s) begin
            rnd_z_s = {sign_s, {(W-1){1'b0}}};
        end else begin
            rnd_z_s = {sign_s, exp_rnd_s[EXP_W-1:0], frac_s};
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_nx_s = special_s ? ST_DONE : ST_MULT;
                else          state_nx_s = ST_IDLE;
            end
            ST_MULT: begin
                if (cnt_r == CW'(ITER - 1)) state_nx_s = ST_ROUND;
                else                        state_nx_s = ST_MULT;
            end
            ST_ROUND: state_nx_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) state_nx_s = ST_IDLE;
                else           state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nx_s;
            out_valid_r <= (state_nx_s == ST_DONE);
            in_ready_r  <= (state_nx_s == ST_IDLE);
        end
    end

    // Operand capture, Booth accumulation and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r    <= '0;
            y_r    <= '0;
            rm_r   <= 3'd0;
            acc_r  <= '0;
            cnt_r  <= '0;
            fp_z_r <= '0;
            ovrf_r <= 1'b0;
            udrf_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_r   <= fp_X;
                        y_r   <= fp_Y;
                        rm_r  <= r_mode;
                        acc_r <= '0;
                        cnt_r <= '0;
                        if (special_s) begin
                            fp_z_r <= spec_z_s;
                            ovrf_r <= 1'b0;
                            udrf_r <= 1'b0;
                        end
                    end
                end
                ST_MULT: begin
                    acc_r <= acc_nx_s;
                    cnt_r <= cnt_r + CW'(1);
                end
                ST_ROUND: begin
                    fp_z_r <= rnd_z_s;
                    ovrf_r <= ovrf_s;
                    udrf_r <= udrf_s;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FP_MUL_NV_FLAG_EN
    logic nv_r;
    logic nv_in_s;

    assign nv_in_s = inv_s | (cls_x_s == CL_SNAN) | (cls_y_s == CL_SNAN);

    // Invalid-operation flag, loaded alongside the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            nv_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && in_valid && special_s) begin
            nv_r <= nv_in_s;
        end else if (state_r == ST_ROUND) begin
            nv_r <= 1'b0;
        end
    end

    assign nv = nv_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign fp_Z      = fp_z_r;
    assign ovrf      = ovrf_r;
    assign udrf      = udrf_r;

endmodule
